// File: rtl/pe_array_pkg.sv
// Shared widths, feeder FSM states and configuration record for the PEArray
// filter feeder and its address generator.
package pe_array_pkg;

    localparam int unsigned ADDR_W           = 16;
    localparam int unsigned ROW_LEN          = 4;
    localparam int unsigned ID_LEN           = 5;
    localparam int unsigned FILTER_DATA_SIZE = 8;
    localparam int unsigned FILTER_NUM       = 4;
    localparam int unsigned BEAT_W           = FILTER_DATA_SIZE * FILTER_NUM;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StRead,
        StLoad,
        StSend,
        StFin
    } feeder_state_e;

    typedef struct packed {
        logic [11:0]       c;
        logic [3:0]        s;
        logic [4:0]        p;
        logic [ADDR_W-1:0] base;
    } feeder_cfg_t;

    // GLB words are little-endian; the PEArray wants the lowest channel in the MSB lane.
    function automatic logic [BEAT_W-1:0] byte_swap(input logic [BEAT_W-1:0] w);
        logic [BEAT_W-1:0] y;
        for (int i = 0; i < FILTER_NUM; i++) begin
            y[(FILTER_NUM-1-i)*FILTER_DATA_SIZE +: FILTER_DATA_SIZE] =
                w[i*FILTER_DATA_SIZE +: FILTER_DATA_SIZE];
        end
        return y;
    endfunction

endpackage

// File: rtl/filter_addr_gen.sv
// Nested s/p/r/c counters producing the GLB byte address of each filter beat
// incrementally from registered per-level base addresses.
module filter_addr_gen
    import pe_array_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               step_i,
    input  logic [ADDR_W-1:0]  base_i,
    input  logic [11:0]        cfg_c_i,
    input  logic [3:0]         cfg_s_i,
    input  logic [4:0]         cfg_p_i,
    input  logic [ADDR_W-1:0]  stride_s_i,
    input  logic [ADDR_W-1:0]  stride_r_i,
    input  logic [ADDR_W-1:0]  stride_p_i,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [ROW_LEN-1:0] c_o,
    output logic [3:0]         r_o,
    output logic               last_o
);

    logic [3:0]        s_q, s_d, r_q, r_d;
    logic [4:0]        p_q, p_d;
    logic [11:0]       c_q, c_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_p_q, addr_p_d, addr_r_q, addr_r_d, addr_c_q, addr_c_d;
    logic [3:0]        s_max;
    logic [4:0]        p_max;
    logic [11:0]       c_max;

    assign s_max = cfg_s_i - 4'd1;
    assign p_max = cfg_p_i - 5'd1;
    assign c_max = cfg_c_i - 12'(FILTER_NUM);

    always_comb begin
        s_d      = s_q;
        p_d      = p_q;
        r_d      = r_q;
        c_d      = c_q;
        addr_d   = addr_q;
        addr_p_d = addr_p_q;
        addr_r_d = addr_r_q;
        addr_c_d = addr_c_q;
        if (clear_i) begin
            s_d      = '0;
            p_d      = '0;
            r_d      = '0;
            c_d      = '0;
            addr_d   = base_i;
            addr_p_d = base_i;
            addr_r_d = base_i;
            addr_c_d = base_i;
        end else if (step_i) begin
            if (s_q != s_max) begin
                s_d    = s_q + 4'd1;
                addr_d = addr_q + stride_s_i;
            end else begin
                s_d = '0;
                if (p_q != p_max) begin
                    p_d      = p_q + 5'd1;
                    addr_p_d = addr_p_q + stride_p_i;
                    addr_d   = addr_p_d;
                end else begin
                    p_d = '0;
                    if (r_q != s_max) begin
                        r_d      = r_q + 4'd1;
                        addr_r_d = addr_r_q + stride_r_i;
                        addr_p_d = addr_r_d;
                        addr_d   = addr_r_d;
                    end else begin
                        r_d      = '0;
                        c_d      = c_q + 12'(FILTER_NUM);
                        addr_c_d = addr_c_q + ADDR_W'(FILTER_NUM);
                        addr_r_d = addr_c_d;
                        addr_p_d = addr_c_d;
                        addr_d   = addr_c_d;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s_q      <= '0;
            p_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            addr_q   <= '0;
            addr_p_q <= '0;
            addr_r_q <= '0;
            addr_c_q <= '0;
        end else begin
            s_q      <= s_d;
            p_q      <= p_d;
            r_q      <= r_d;
            c_q      <= c_d;
            addr_q   <= addr_d;
            addr_p_q <= addr_p_d;
            addr_r_q <= addr_r_d;
            addr_c_q <= addr_c_d;
        end
    end

    assign addr_o = addr_q;
    assign c_o    = c_q[ROW_LEN-1:0];
    assign r_o    = r_q;
    assign last_o = (s_q == s_max) && (p_q == p_max) && (r_q == s_max) && (c_q == c_max);

endmodule

// File: rtl/filter_feeder.sv
// Filter feeder: reads GLB words and hands them to the PEArray filter port as
// tagged beats, one read/load/send round per beat.
module filter_feeder
    import pe_array_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  cfg_base,
    input  logic [11:0]        config_C,
    input  logic [3:0]         config_S,
    input  logic [4:0]         config_p,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               glb_ren,
    output logic [ADDR_W-1:0]  glb_raddr,
    input  logic [BEAT_W-1:0]  glb_rdata,
    output logic               filter_enable,
    input  logic               filter_ready,
    output logic [ROW_LEN-1:0] filter_row_tag,
    output logic [ID_LEN-1:0]  filter_col_tag,
    output logic [BEAT_W-1:0]  filter_value
);

    feeder_state_e     state_q;
    feeder_cfg_t       cfg_q;
    logic [ADDR_W-1:0] stride_s_q, stride_r_q, stride_p_q;
    logic              last_q;
    logic              cfg_bad;
    logic              gen_clear, gen_step, gen_last;
    logic [ADDR_W-1:0] gen_addr;
    logic [ROW_LEN-1:0] gen_c;
    logic [3:0]        gen_r;

    assign cfg_bad = (cfg_q.c == '0) || (cfg_q.s == '0) || (cfg_q.p == '0) ||
                     ((cfg_q.c & 12'(FILTER_NUM - 1)) != '0);

    // Counters advance as soon as a beat is loaded so the next address is ready at handshake.
    assign gen_clear = (state_q == StCheck);
    assign gen_step  = (state_q == StLoad);

    filter_addr_gen u_addr_gen (
        .clk_i      (clk),
        .rst_ni     (rst),
        .clear_i    (gen_clear),
        .step_i     (gen_step),
        .base_i     (cfg_q.base),
        .cfg_c_i    (cfg_q.c),
        .cfg_s_i    (cfg_q.s),
        .cfg_p_i    (cfg_q.p),
        .stride_s_i (stride_s_q),
        .stride_r_i (stride_r_q),
        .stride_p_i (stride_p_q),
        .addr_o     (gen_addr),
        .c_o        (gen_c),
        .r_o        (gen_r),
        .last_o     (gen_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            cfg_q          <= '0;
            stride_s_q     <= '0;
            stride_r_q     <= '0;
            stride_p_q     <= '0;
            last_q         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            glb_ren        <= 1'b0;
            glb_raddr      <= '0;
            filter_enable  <= 1'b0;
            filter_row_tag <= '0;
            filter_col_tag <= '0;
            filter_value   <= '0;
        end else begin
            done    <= 1'b0;
            glb_ren <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cfg_q   <= '{c: config_C, s: config_S, p: config_p, base: cfg_base};
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    stride_s_q <= ADDR_W'(cfg_q.c);
                    stride_r_q <= ADDR_W'(cfg_q.s) * ADDR_W'(cfg_q.c);
                    stride_p_q <= ADDR_W'(cfg_q.s) * ADDR_W'(cfg_q.s) * ADDR_W'(cfg_q.c);
                    if (cfg_bad) begin
                        err     <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StFin;
                    end else begin
                        glb_ren   <= 1'b1;
                        glb_raddr <= cfg_q.base;
                        state_q   <= StRead;
                    end
                end
                StRead: state_q <= StLoad;
                StLoad: begin
                    filter_value   <= byte_swap(glb_rdata);
                    filter_row_tag <= gen_c;
                    filter_col_tag <= ID_LEN'(gen_r);
                    last_q         <= gen_last;
                    filter_enable  <= 1'b1;
                    state_q        <= StSend;
                end
                StSend: begin
                    if (filter_ready) begin
                        filter_enable <= 1'b0;
                        if (last_q) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StFin;
                        end else begin
                            glb_ren   <= 1'b1;
                            glb_raddr <= gen_addr;
                            state_q   <= StRead;
                        end
                    end
                end
                StFin:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_feeder.sv
// Randomised bench for filter_feeder: a GLB byte-array model, a loop-nest reference
// of the expected beat stream, and directed latency/backpressure/error/reset cases.
module tb_filter_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_base = '0;
    logic [11:0] config_C = '0;
    logic [3:0]  config_S = '0;
    logic [4:0]  config_p = '0;
    logic        busy, done, err, glb_ren, filter_enable;
    logic [15:0] glb_raddr;
    logic [31:0] glb_rdata = '0;
    logic        filter_ready = 1'b0;
    logic [3:0]  filter_row_tag;
    logic [4:0]  filter_col_tag;
    logic [31:0] filter_value;

    filter_feeder dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_base       (cfg_base),
        .config_C       (config_C),
        .config_S       (config_S),
        .config_p       (config_p),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .glb_ren        (glb_ren),
        .glb_raddr      (glb_raddr),
        .glb_rdata      (glb_rdata),
        .filter_enable  (filter_enable),
        .filter_ready   (filter_ready),
        .filter_row_tag (filter_row_tag),
        .filter_col_tag (filter_col_tag),
        .filter_value   (filter_value)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] mem [0:65535];

    function automatic logic [31:0] glb_word(input logic [15:0] a);
        return {mem[16'(a + 16'd3)], mem[16'(a + 16'd2)], mem[16'(a + 16'd1)], mem[a]};
    endfunction

    always @(posedge clk) if (glb_ren) glb_rdata <= glb_word(glb_raddr);

    // Reference beat stream straight from the loop nest and address formula.
    logic [15:0] exp_addr_q[$];
    logic [31:0] exp_val_q[$];
    logic [3:0]  exp_row_q[$];
    logic [4:0]  exp_col_q[$];

    task automatic flush_model();
        exp_addr_q.delete();
        exp_val_q.delete();
        exp_row_q.delete();
        exp_col_q.delete();
    endtask

    task automatic build_model(input logic [15:0] b, input int cn, input int sn, input int pn);
        logic [15:0] a;
        if (cn == 0 || (cn % 4) != 0 || sn == 0 || pn == 0) return;
        for (int c = 0; c < cn; c += 4)
            for (int r = 0; r < sn; r++)
                for (int p = 0; p < pn; p++)
                    for (int s = 0; s < sn; s++) begin
                        a = b + 16'(((p * sn + r) * sn + s) * cn + c);
                        exp_addr_q.push_back(a);
                        exp_val_q.push_back({mem[a], mem[16'(a + 16'd1)],
                                             mem[16'(a + 16'd2)], mem[16'(a + 16'd3)]});
                        exp_row_q.push_back(4'(c));
                        exp_col_q.push_back(5'(r));
                    end
    endtask

    int          beat_cnt = 0;
    int          done_cnt = 0;
    int          n_reads  = 0;
    logic [15:0] obs_addr [0:63];
    logic [31:0] last_val = '0;

    always @(negedge clk) begin
        if (rst) begin
            if (glb_ren) begin
                if (exp_addr_q.size() == 0) begin
                    check_eq("unexpected_read", 64'(glb_ren), 64'd0);
                end else begin
                    if (n_reads < 64) obs_addr[n_reads] = glb_raddr;
                    n_reads++;
                    check_eq("raddr", 64'(glb_raddr), 64'(exp_addr_q.pop_front()));
                end
            end
            if (filter_enable && filter_ready) begin
                beat_cnt++;
                last_val = filter_value;
                if (exp_val_q.size() == 0) begin
                    check_eq("extra_beat", 64'(filter_enable), 64'd0);
                end else begin
                    check_eq("value", 64'(filter_value), 64'(exp_val_q.pop_front()));
                    check_eq("row_tag", 64'(filter_row_tag), 64'(exp_row_q.pop_front()));
                    check_eq("col_tag", 64'(filter_col_tag), 64'(exp_col_q.pop_front()));
                end
            end
            if (done) done_cnt++;
        end
    end

    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rand_ready) filter_ready = 1'($urandom_range(0, 1));
    end

    task automatic pulse_start(input logic [15:0] b, input int cn, input int sn, input int pn);
        cfg_base = b;
        config_C = 12'(cn);
        config_S = 4'(sn);
        config_p = 5'(pn);
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int cyc = 0;
        while (!done && cyc < max_cyc) begin
            @(posedge clk);
            #1 cyc++;
        end
        if (!done) check_eq("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic prep(input logic [15:0] b, input int cn, input int sn, input int pn);
        flush_model();
        build_model(b, cn, sn, pn);
        beat_cnt = 0;
        done_cnt = 0;
        n_reads  = 0;
    endtask

    task automatic finish_pass(input string name, input int exp_beats);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq({name, "_beats"}, 64'(beat_cnt), 64'(exp_beats));
        check_eq({name, "_left"}, 64'(exp_val_q.size()), 64'd0);
        check_eq({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check_eq({name, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    task automatic run_pass(input string name, input logic [15:0] b,
                            input int cn, input int sn, input int pn);
        int n;
        prep(b, cn, sn, pn);
        n = exp_val_q.size();
        pulse_start(b, cn, sn, pn);
        check_eq({name, "_busy"}, 64'(busy), 64'd1);
        wait_done(n * 40 + 50);
        finish_pass(name, n);
    endtask

    task automatic check_idle_outputs(input string name);
        check_eq({name, "_busy"}, 64'(busy), 64'd0);
        check_eq({name, "_done"}, 64'(done), 64'd0);
        check_eq({name, "_err"}, 64'(err), 64'd0);
        check_eq({name, "_ren"}, 64'(glb_ren), 64'd0);
        check_eq({name, "_raddr"}, 64'(glb_raddr), 64'd0);
        check_eq({name, "_enable"}, 64'(filter_enable), 64'd0);
        check_eq({name, "_value"}, 64'(filter_value), 64'd0);
        check_eq({name, "_tags"}, 64'({filter_row_tag, filter_col_tag}), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          guard;
        logic [31:0] hv;
        logic [3:0]  hr;
        logic [4:0]  hc;
        logic [15:0] b;
        int          cn, sn, pn;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0100] = 8'h11;
        mem[16'h0101] = 8'h22;
        mem[16'h0102] = 8'h33;
        mem[16'h0103] = 8'h44;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b1;
        filter_ready = 1'b1;
        @(posedge clk);
        #1;

        // Single beat, latency from start to first enable.
        prep(16'h0100, 4, 1, 1);
        pulse_start(16'h0100, 4, 1, 1);
        lat = 1;
        while (!filter_enable && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check_eq("t1_latency", 64'(lat), 64'd4);
        wait_done(20);
        finish_pass("t1", 1);
        check_eq("t1_value", 64'(last_val), 64'h11223344);

        // Full 36-beat pass with ready held high.
        run_pass("t2", 16'h0000, 8, 3, 2);
        check_eq("t2_addr1", 64'(obs_addr[1]), 64'd8);
        check_eq("t2_addr2", 64'(obs_addr[2]), 64'd16);
        check_eq("t2_addr3", 64'(obs_addr[3]), 64'd72);
        check_eq("t2_addr6", 64'(obs_addr[6]), 64'd24);
        check_eq("t2_addr18", 64'(obs_addr[18]), 64'd4);

        // Backpressure on beat 1.
        prep(16'h0000, 8, 3, 2);
        filter_ready = 1'b0;
        pulse_start(16'h0000, 8, 3, 2);
        guard = 0;
        while (!filter_enable && guard < 20) begin
            @(posedge clk);
            #1 guard++;
        end
        filter_ready = 1'b1;
        @(posedge clk);
        #1 filter_ready = 1'b0;
        guard = 0;
        while (!filter_enable && guard < 20) begin
            @(posedge clk);
            #1 guard++;
        end
        hv = filter_value;
        hr = filter_row_tag;
        hc = filter_col_tag;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_enable", 64'(filter_enable), 64'd1);
            check_eq("bp_value", 64'(filter_value), 64'(hv));
            check_eq("bp_tags", 64'({filter_row_tag, filter_col_tag}), 64'({hr, hc}));
            check_eq("bp_ren", 64'(glb_ren), 64'd0);
        end
        filter_ready = 1'b1;
        wait_done(400);
        finish_pass("bp", 36);

        // Bad channel count: error, quick done, no reads.
        prep(16'h0000, 6, 3, 2);
        pulse_start(16'h0000, 6, 3, 2);
        @(posedge clk);
        #1;
        check_eq("err_done", 64'(done), 64'd1);
        check_eq("err_flag", 64'(err), 64'd1);
        check_eq("err_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check_eq("err_done_pulse", 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("err_sticky", 64'(err), 64'd1);
        check_eq("err_reads", 64'(n_reads), 64'd0);
        run_pass("err_clear", 16'h0100, 4, 1, 1);
        check_eq("err_cleared", 64'(err), 64'd0);

        // Reset after beat 10, then replay from beat 0.
        prep(16'h2000, 8, 3, 2);
        pulse_start(16'h2000, 8, 3, 2);
        guard = 0;
        while (beat_cnt < 11 && guard < 200) begin
            @(posedge clk);
            #1 guard++;
        end
        check_eq("rst_reached", 64'(beat_cnt), 64'd11);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        check_idle_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        run_pass("replay", 16'h2000, 8, 3, 2);

        // Second start mid-pass must be ignored.
        prep(16'h0040, 8, 3, 2);
        pulse_start(16'h0040, 8, 3, 2);
        guard = 0;
        while (beat_cnt < 5 && guard < 200) begin
            @(posedge clk);
            #1 guard++;
        end
        pulse_start(16'h0300, 4, 1, 1);
        wait_done(400);
        finish_pass("restart", 36);

        // Random configurations with random backpressure, one near address wrap.
        rand_ready = 1'b1;
        for (int it = 0; it < 6; it++) begin
            cn = 4 * int'($urandom_range(1, 4));
            sn = int'($urandom_range(1, 3));
            pn = int'($urandom_range(1, 3));
            b  = (it == 0) ? 16'hFFF0 : 16'($urandom) & 16'hFFFC;
            run_pass("rand", b, cn, sn, pn);
        end
        rand_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
